phase_sequence_monitor: RTL and testbench
=========================================

Name: phase_sequence_monitor

Overview:
- Downstream consumer of the 4-phase one-hot pulse generator's q[3:0] bus.
- Checks that the phases rotate in the expected order and locks once the rotation is confirmed.
- While locked, counts complete phase revolutions and flags any sequence error.
- Status outputs feed board LEDs and system-level health logic.

Parameters:
- CNT_W, 8: width of the revolution counter; the counter wraps modulo 2^CNT_W.
- LOCK_CNT, 4: consecutive valid steps required to enter LOCKED; legal range 1..15.
- DIR, 0: expected rotation. 0 = rotate-left (0001->0010->0100->1000->0001); 1 = rotate-right.
- ALLOW_HOLD, 1: 1 = a repeated identical phase is legal; 0 = a repeat counts as an error.

Ports:
- clk, input, 1: single system clock, rising edge.
- rs, input, 1: synchronous, active-high reset.
- q_in, input, 4: phase vector from the pulse generator.
- locked, output, 1: high while the FSM is in LOCKED.
- err, output, 1: one-cycle pulse on a sequence violation while LOCKED.
- cycle_done, output, 1: one-cycle pulse on each wrap while LOCKED.
- cycle_cnt, output, CNT_W: count of completed revolutions.
- phase_idx, output, 2: binary index of the current phase; 0 when not locked.

Behaviour:
- Reset:
  - rs is sampled only at the rising edge of clk.
  - On reset: state=IDLE, prev=0000, step_cnt=0, cycle_cnt=0.
  - On reset: locked=0, err=0, cycle_done=0, phase_idx=0.
  - rs has priority over every other event, including mid-lock; the next edge after rs yields all zeros.
- Sampling:
  - Each edge samples cur=q_in and classifies it against prev (the previous registered sample), then sets prev<=cur.
- Classification of cur (combinational):
  - BAD: cur is not one-hot (0000 and multi-hot included).
  - HOLD: cur==prev.
  - STEP: cur==rot(prev,DIR).
  - BAD: anything else, e.g. a skipped phase or a reversal.
  - HOLD with ALLOW_HOLD=0 is treated as BAD.
- Latency: all outputs are registered and update on the same edge that samples q_in, i.e. one clock after q_in changes.
- FSM state IDLE:
  - cur one-hot -> ACQUIRE, step_cnt=0.
  - Otherwise stay in IDLE.
- FSM state ACQUIRE:
  - STEP -> step_cnt+1. If step_cnt+1==LOCK_CNT -> LOCKED, step_cnt=0.
  - HOLD (allowed) -> no change.
  - BAD with cur one-hot -> restart ACQUIRE with step_cnt=0.
  - BAD with cur not one-hot -> IDLE.
  - err is never asserted in ACQUIRE.
- FSM state LOCKED:
  - STEP -> stay in LOCKED.
  - STEP into the wrap phase (0001 for DIR=0; 1000 for DIR=1) -> cycle_cnt+1 and cycle_done=1 for one cycle.
  - HOLD (allowed) -> stay in LOCKED, no pulse.
  - BAD -> err=1 for one cycle, locked drops on the same edge. Next state is ACQUIRE (step_cnt=0) if cur is one-hot, else IDLE.
- Boundary rules:
  - The wrap step that completes locking is not counted as a revolution; counting starts only from LOCKED.
  - cycle_cnt holds its value across lock loss; only rs clears it.
  - cycle_cnt overflow wraps silently to 0, and cycle_done still pulses.
  - err and cycle_done are mutually exclusive by construction.
- phase_idx: encoder of cur when the next state is LOCKED, else 0.

Decomposition:
- Shared package phase_mon_pkg:
  - state enum {IDLE, ACQUIRE, LOCKED}.
  - class enum {STEP, HOLD, BAD}.
  - Function is_onehot4.
  - Function rot4(v, dir).
  - Function onehot_to_idx.
- One natural sub-module, phase_step_classifier: purely combinational (cur, prev -> class). It is reusable by other phase-bus monitors.
- The FSM, counters and output registers stay in the top-level module.

Test Plan (defaults unless stated; one q_in value per clock):
- Reset: rs=1 for 2 clocks with q_in=0001 -> all outputs 0; after release with q_in=0000 held, stays IDLE with locked=0.
- Lock and count: q_in 0001,0010,0100,1000,0001 -> locked=1 after the 5th edge with cycle_cnt=0; 12 further steps -> 3 cycle_done pulses, each on a 0001 sample; cycle_cnt=3; phase_idx tracks 0..3.
- Hold: while locked, hold 0100 for 5 clocks -> locked stays 1, err=0. Repeat with ALLOW_HOLD=0 -> err on the first repeat, locked=0.
- Skip error: while locked at 0010, apply 1000 -> err for 1 cycle, locked=0, state ACQUIRE. Then 0001,0010,0100,1000 -> re-lock on the 4th step; cycle_cnt unchanged.
- Invalid vector: while locked, apply 0110 -> err pulse, IDLE. Then 0000 for 3 clocks -> stays IDLE, no err.
- Reset mid-lock and wrap: CNT_W=2; run 5 revolutions -> cycle_cnt sequence 1,2,3,0,1. Assert rs while locked -> next edge gives cycle_cnt=0, locked=0.

Source files
------------

// File: rtl/phase_mon_pkg.sv
// phase_mon_pkg: shared types and helpers for 4-phase one-hot bus monitors
package phase_mon_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;
  typedef enum logic [1:0] {STEP, HOLD, BAD} step_class_e;
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction
  function automatic logic [3:0] rot4(input logic [3:0] v, input logic dir);
    return dir ? {v[0], v[3:1]} : {v[2:0], v[3]};
  endfunction
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    return {v[3] | v[2], v[3] | v[1]};
  endfunction
endpackage

// File: rtl/phase_step_classifier.sv
// phase_step_classifier: classifies a phase sample against the previous one
module phase_step_classifier
  import phase_mon_pkg::*;
#(
  parameter bit DIR        = 1'b0,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic [3:0]  cur,
  input  logic [3:0]  prev,
  output step_class_e cls
);
  // non-one-hot, disallowed repeats, skips and reversals are all BAD
  always_comb begin
    cls = !is_onehot4(cur) ? BAD :
          (cur == prev) ? (ALLOW_HOLD ? HOLD : BAD) :
          (cur == rot4(prev, DIR)) ? STEP : BAD;
  end
endmodule

// File: rtl/phase_sequence_monitor.sv
// phase_sequence_monitor: locks onto a rotating one-hot phase bus and counts revolutions
module phase_sequence_monitor
  import phase_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int LOCK_CNT   = 4,
  parameter bit DIR        = 1'b0,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [3:0]       q_in,
  output logic             locked,
  output logic             err,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       phase_idx
);
  localparam logic [3:0] WRAP = DIR ? 4'b1000 : 4'b0001;
  state_e           state_q, state_d;
  logic [3:0]       prev_q, step_cnt_q, step_cnt_d, step_inc;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             locked_q, err_q, err_d, cycle_done_q, cycle_done_d;
  logic [1:0]       phase_idx_q, phase_idx_d;
  logic             onehot, lock_hit;
  step_class_e      cls;
  phase_step_classifier #(.DIR(DIR), .ALLOW_HOLD(ALLOW_HOLD)) u_cls (
    .cur (q_in),
    .prev(prev_q),
    .cls (cls)
  );
  assign onehot   = is_onehot4(q_in);
  assign step_inc = step_cnt_q + 4'd1;
  assign lock_hit = step_inc == 4'(LOCK_CNT);
  // next-state, counter and pulse decisions for the current sample
  always_comb begin
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    err_d        = 1'b0;
    cycle_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d    = onehot ? ACQUIRE : IDLE;
        step_cnt_d = 4'd0;
      end
      ACQUIRE: begin
        if (cls == STEP) begin
          state_d    = lock_hit ? LOCKED : ACQUIRE;
          step_cnt_d = lock_hit ? 4'd0 : step_inc;
        end else if (cls == BAD) begin
          state_d    = onehot ? ACQUIRE : IDLE;
          step_cnt_d = 4'd0;
        end
      end
      LOCKED: begin
        if (cls == BAD) begin
          err_d      = 1'b1;
          state_d    = onehot ? ACQUIRE : IDLE;
          step_cnt_d = 4'd0;
        end else if (cls == STEP && q_in == WRAP) begin
          cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
          cycle_done_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        step_cnt_d = 4'd0;
      end
    endcase
    phase_idx_d = (state_d == LOCKED) ? onehot_to_idx(q_in) : 2'd0;
  end
  // state, sample history and registered outputs
  always_ff @(posedge clk) begin
    if (rs) begin
      state_q      <= IDLE;
      prev_q       <= 4'd0;
      step_cnt_q   <= 4'd0;
      cycle_cnt_q  <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      cycle_done_q <= 1'b0;
      phase_idx_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      prev_q       <= q_in;
      step_cnt_q   <= step_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      locked_q     <= state_d == LOCKED;
      err_q        <= err_d;
      cycle_done_q <= cycle_done_d;
      phase_idx_q  <= phase_idx_d;
    end
  end
  assign locked     = locked_q;
  assign err        = err_q;
  assign cycle_done = cycle_done_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign phase_idx  = phase_idx_q;
endmodule

// File: tb/tb_phase_sequence_monitor.sv
// tb_phase_sequence_monitor: scoreboard bench over default, no-hold and narrow-counter variants
module tb_phase_sequence_monitor;
  logic clk = 1'b0;
  logic rs = 1'b1;
  logic [3:0] q_in = 4'b0000;
  logic l0, e0, d0, l1, e1, d1, l2, e2, d2;
  logic [1:0] i0, i1, i2, c2;
  logic [7:0] c0, c1;
  logic [12:0] o [3];
  logic [12:0] sb [$];
  int tests = 0;
  int fails = 0;
  int m_st [3];
  int m_steps [3];
  int m_cnt [3];
  logic [3:0] m_prev [3];
  int hold_ok [3] = '{1, 0, 1};
  int cw [3] = '{8, 8, 2};
  int cyc = 0;
  always #5 clk = ~clk;
  phase_sequence_monitor u0 (.clk(clk), .rs(rs), .q_in(q_in), .locked(l0), .err(e0),
    .cycle_done(d0), .cycle_cnt(c0), .phase_idx(i0));
  phase_sequence_monitor #(.ALLOW_HOLD(1'b0)) u1 (.clk(clk), .rs(rs), .q_in(q_in), .locked(l1),
    .err(e1), .cycle_done(d1), .cycle_cnt(c1), .phase_idx(i1));
  phase_sequence_monitor #(.CNT_W(2)) u2 (.clk(clk), .rs(rs), .q_in(q_in), .locked(l2), .err(e2),
    .cycle_done(d2), .cycle_cnt(c2), .phase_idx(i2));
  assign o[0] = {l0, e0, d0, i0, c0};
  assign o[1] = {l1, e1, d1, i1, c1};
  assign o[2] = {l2, e2, d2, i2, 6'd0, c2};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference: state 0=idle 1=acquire 2=locked; expected successor of prev found by shifting
  function automatic logic [12:0] model(input int k, input logic r, input logic [3:0] q);
    logic oh, stp, hld, bad, er, dn;
    logic [3:0] nxt;
    logic [1:0] idx;
    er = 1'b0;
    dn = 1'b0;
    if (r) begin
      m_st[k] = 0; m_steps[k] = 0; m_cnt[k] = 0; m_prev[k] = 4'b0000;
      return 13'd0;
    end
    oh  = $countones(q) == 1;
    nxt = (m_prev[k] == 4'b1000) ? 4'b0001 : (m_prev[k] << 1);
    stp = oh && q == nxt;
    hld = oh && q == m_prev[k];
    bad = !stp && !(hld && hold_ok[k] == 1);
    if (m_st[k] == 0) begin
      if (oh) m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      if (stp) begin
        m_steps[k]++;
        if (m_steps[k] == 4) begin m_st[k] = 2; m_steps[k] = 0; end
      end else if (bad) begin
        m_st[k] = oh ? 1 : 0; m_steps[k] = 0;
      end
    end else begin
      if (bad) begin
        er = 1'b1; m_st[k] = oh ? 1 : 0; m_steps[k] = 0;
      end else if (stp && q == 4'b0001) begin
        dn = 1'b1; m_cnt[k] = (m_cnt[k] + 1) % (1 << cw[k]);
      end
    end
    m_prev[k] = q;
    idx = 2'd0;
    for (int b = 0; b < 4; b++) if (m_st[k] == 2 && q[b]) idx = 2'(b);
    return {m_st[k] == 2, er, dn, idx, 8'(m_cnt[k])};
  endfunction
  task automatic drive(input logic r, input logic [3:0] q);
    rs = r;
    q_in = q;
    for (int k = 0; k < 3; k++) sb.push_back(model(k, r, q));
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) check($sformatf("sb c%0d u%0d q=%b", cyc, k, q), 32'(o[k]), 32'(sb.pop_front()));
  endtask
  task automatic rev();
    drive(0, 4'b0010); drive(0, 4'b0100); drive(0, 4'b1000); drive(0, 4'b0001);
  endtask
  initial begin
    int pulses;
    int saved;
    int exp_seq [5] = '{1, 2, 3, 0, 1};
    @(negedge clk);
    drive(1, 4'b0001); drive(1, 4'b0001);
    check("reset_locked", 32'(l0), 0);
    for (int n = 0; n < 3; n++) drive(0, 4'b0000);
    check("idle_locked", 32'(l0), 0);
    drive(0, 4'b0001); drive(0, 4'b0010); drive(0, 4'b0100); drive(0, 4'b1000);
    check("pre_lock", 32'(l0), 0);
    drive(0, 4'b0001);
    check("lock", 32'(l0), 1);
    check("lock_cnt", 32'(c0), 0);
    pulses = 0;
    for (int n = 0; n < 3; n++) begin
      drive(0, 4'b0010); pulses += int'(d0);
      check("idx1", 32'(i0), 1);
      drive(0, 4'b0100); pulses += int'(d0);
      drive(0, 4'b1000); pulses += int'(d0);
      check("idx3", 32'(i0), 3);
      drive(0, 4'b0001); pulses += int'(d0);
      check("wrap_pulse", 32'(d0), 1);
    end
    check("pulses", 32'(pulses), 3);
    check("cnt3", 32'(c0), 3);
    drive(0, 4'b0010);
    drive(0, 4'b0100);
    drive(0, 4'b0100);
    check("nohold_err", 32'(e1), 1);
    check("hold_ok_err", 32'(e0), 0);
    for (int n = 0; n < 3; n++) drive(0, 4'b0100);
    check("hold_locked", 32'(l0), 1);
    check("nohold_locked", 32'(l1), 0);
    drive(0, 4'b1000); drive(0, 4'b0001); drive(0, 4'b0010); drive(0, 4'b0100);
    drive(0, 4'b1000); drive(0, 4'b0001); drive(0, 4'b0010);
    saved = int'(c0);
    drive(0, 4'b1000);
    check("skip_err", 32'(e0), 1);
    check("skip_locked", 32'(l0), 0);
    drive(0, 4'b0001); drive(0, 4'b0010); drive(0, 4'b0100);
    check("relock_early", 32'(l0), 0);
    drive(0, 4'b1000);
    check("relock", 32'(l0), 1);
    check("relock_cnt", 32'(c0), 32'(saved));
    drive(0, 4'b0001);
    drive(0, 4'b0110);
    check("inv_err", 32'(e0), 1);
    for (int n = 0; n < 3; n++) begin
      drive(0, 4'b0000);
      check("idle_err", 32'(e0), 0);
    end
    drive(1, 4'b0000);
    drive(0, 4'b0001); drive(0, 4'b0010); drive(0, 4'b0100); drive(0, 4'b1000); drive(0, 4'b0001);
    for (int n = 0; n < 5; n++) begin
      rev();
      check($sformatf("wrap_seq%0d", n), 32'(c2), 32'(exp_seq[n]));
      check("wrap_done", 32'(d2), 1);
    end
    drive(0, 4'b0010);
    drive(1, 4'b0100);
    check("rs_cnt", 32'(c2), 0);
    check("rs_locked", 32'(l2), 0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
